boot_run_ctrl: RTL
==================

BOOT_RUN_CTRL -- requirements
Module: boot_run_ctrl

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 18, word width of loaded program.
REQ-002 SHALL have parameter ADDRESS_BUS_WIDTH, default 14, memory address width.
REQ-003 SHALL have parameter RUN_CYCLES, default 50, CPU cycle budget before timeout.
REQ-004 SHALL have parameter HALT_WORD, default all ones, instruction value that ends a run.
REQ-005 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: i_start in 1 start pulse; i_load_valid in 1; i_load_data in INSTRUCTION_WIDTH; i_load_last in 1; o_load_ready out 1.
REQ-007 SHALL have ports: o_mem_write out 1; o_mem_addr out ADDRESS_BUS_WIDTH; o_mem_wdata out INSTRUCTION_WIDTH.
REQ-008 SHALL have ports: o_cpu_rst out 1; i_instruction in INSTRUCTION_WIDTH (CPU fetch monitor).
REQ-009 SHALL have ports: o_busy out 1; o_done out 1; o_timeout out 1; o_overflow out 1; o_checksum_err out 1; o_cycle_count out 32; o_load_count out ADDRESS_BUS_WIDTH+1; i_expected_checksum in INSTRUCTION_WIDTH.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, RELEASE, RUN, DONE.
REQ-011 IDLE: o_cpu_rst=1, o_load_ready=0, o_busy=0; i_start -> LOAD, load address and o_load_count cleared to 0.
REQ-012 LOAD: o_load_ready=1, o_busy=1; word accepted when i_load_valid && o_load_ready.
REQ-013 Accepted word SHALL appear as o_mem_write=1, o_mem_wdata=word, o_mem_addr=current address on the next cycle (1-cycle registered latency); o_mem_write=0 otherwise.
REQ-014 Each accept SHALL increment address and o_load_count by 1.
REQ-015 Accept with i_load_last=1 -> RELEASE.
REQ-016 Accept at address 2^ADDRESS_BUS_WIDTH-1 without i_load_last SHALL set sticky o_overflow and -> RELEASE; address never wraps.
REQ-017 RELEASE: one cycle, o_cpu_rst=1, o_load_ready=0, o_cycle_count cleared; -> RUN.
REQ-018 RUN: o_cpu_rst=0, o_busy=1, o_cycle_count increments by 1 per cycle.
REQ-019 RUN: i_instruction == HALT_WORD -> DONE with o_done=1.
REQ-020 RUN: o_cycle_count reaching RUN_CYCLES -> DONE with o_done=1, o_timeout=1.
REQ-021 Halt and budget expiry in same cycle: halt wins, o_timeout=0.
REQ-022 DONE: o_cpu_rst=1, o_busy=0, flags and counts held; i_start -> LOAD clearing o_done, o_timeout, o_overflow, o_checksum_err.
REQ-023 i_start SHALL be ignored in LOAD, RELEASE, RUN.
REQ-024 o_cycle_count SHALL saturate at 2^32-1.

Reset
REQ-025 i_rst SHALL force IDLE at next clock edge from any state, including mid-load and mid-run.
REQ-026 Reset values: o_cpu_rst=1; o_load_ready, o_mem_write, o_busy, o_done, o_timeout, o_overflow, o_checksum_err = 0; o_mem_addr, o_mem_wdata, o_cycle_count, o_load_count = 0.
REQ-027 A word presented in the reset cycle SHALL not be written.

Configuration
REQ-028 Macro BOOT_CHECKSUM_EN defined: accepted words summed modulo 2^INSTRUCTION_WIDTH; on leaving LOAD, sum != i_expected_checksum -> DONE directly with o_checksum_err=1, o_done=1, CPU never released; match -> RELEASE.
REQ-029 Macro undefined: no checksum logic, o_checksum_err tied 0, i_expected_checksum unused.

Verification
REQ-030 Start, load 4 words 0x00001..0x00004 with last on 4th -> writes at addr 0..3 one cycle after each accept, o_load_count=4, RELEASE for 1 cycle, then o_cpu_rst=0.
REQ-031 In RUN, drive i_instruction=0x3FFFF at run cycle 10 -> DONE, o_done=1, o_timeout=0, o_cycle_count=10.
REQ-032 Never drive HALT_WORD, RUN_CYCLES=50 -> o_timeout=1, o_done=1, o_cycle_count=50; halt at cycle 50 -> o_timeout=0.
REQ-033 ADDRESS_BUS_WIDTH=3, stream 9 words without last -> 8 writes (addr 0..7), o_overflow=1, 9th word not accepted.
REQ-034 Assert i_rst after 2 of 4 load words -> IDLE next cycle, o_cpu_rst=1, no further writes; i_start restarts at addr 0.
REQ-035 BOOT_CHECKSUM_EN: words 1,2,3 with expected 6 -> RUN; expected 7 -> o_checksum_err=1, o_cpu_rst stays 1.

Source files
------------

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: loads a program into memory, releases the CPU, and watches for halt or timeout (optional load checksum via BOOT_CHECKSUM_EN).
module boot_run_ctrl #(
    parameter int INSTRUCTION_WIDTH = 18,
    parameter int ADDRESS_BUS_WIDTH = 14,
    parameter int RUN_CYCLES = 50,
    parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD = '1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_load_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_load_data,
    input  logic                         i_load_last,
    output logic                         o_load_ready,
    output logic                         o_mem_write,
    output logic [ADDRESS_BUS_WIDTH-1:0] o_mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] o_mem_wdata,
    output logic                         o_cpu_rst,
    input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_timeout,
    output logic                         o_overflow,
    output logic                         o_checksum_err,
    output logic [31:0]                  o_cycle_count,
    output logic [ADDRESS_BUS_WIDTH:0]   o_load_count,
    input  logic [INSTRUCTION_WIDTH-1:0] i_expected_checksum
);
    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;
    localparam logic [ADDRESS_BUS_WIDTH:0] LAST_ADDR = {1'b0, {ADDRESS_BUS_WIDTH{1'b1}}};
    state_t state_q, state_d;
    logic load_ready_q, load_ready_d, mem_write_q, mem_write_d, cpu_rst_q, cpu_rst_d;
    logic busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic chk_err_q, chk_err_d;
    logic [ADDRESS_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata_q, mem_wdata_d, sum_q, sum_d, sum_next;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [ADDRESS_BUS_WIDTH:0] load_count_q, load_count_d;
    logic accept;
    always_comb begin
        state_d = state_q;
        mem_write_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cycle_count_d = cycle_count_q;
        load_count_d = load_count_q;
        done_d = done_q;
        timeout_d = timeout_q;
        overflow_d = overflow_q;
        chk_err_d = chk_err_q;
        sum_d = sum_q;
        sum_next = sum_q + i_load_data;
        accept = state_q == LOAD && i_load_valid && load_ready_q;
        case (state_q)
            IDLE, DONE: if (i_start) begin
                state_d = LOAD;
                load_count_d = '0;
                done_d = 1'b0;
                timeout_d = 1'b0;
                overflow_d = 1'b0;
                chk_err_d = 1'b0;
                sum_d = '0;
            end
            LOAD: if (accept) begin
                mem_write_d = 1'b1;
                mem_addr_d = load_count_q[ADDRESS_BUS_WIDTH-1:0];
                mem_wdata_d = i_load_data;
                load_count_d = load_count_q + 1'b1;
                sum_d = sum_next;
                if (i_load_last || load_count_q == LAST_ADDR) begin
                    overflow_d = !i_load_last;
                    state_d = RELEASE;
                    cycle_count_d = '0;
`ifdef BOOT_CHECKSUM_EN
                    if (sum_next != i_expected_checksum) begin
                        state_d = DONE;
                        chk_err_d = 1'b1;
                        done_d = 1'b1;
                    end
`endif
                end
            end
            RELEASE: state_d = RUN;
            RUN: begin
                cycle_count_d = &cycle_count_q ? cycle_count_q : cycle_count_q + 32'd1;
                if (i_instruction == HALT_WORD) begin
                    state_d = DONE;
                    done_d = 1'b1;
                end else if (cycle_count_d >= 32'(RUN_CYCLES)) begin
                    state_d = DONE;
                    done_d = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cpu_rst_d = state_d != RUN;
        load_ready_d = state_d == LOAD;
        busy_d = state_d == LOAD || state_d == RELEASE || state_d == RUN;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            load_ready_q <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            timeout_q <= 1'b0;
            overflow_q <= 1'b0;
            chk_err_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            sum_q <= '0;
            cycle_count_q <= '0;
            load_count_q <= '0;
        end else begin
            state_q <= state_d;
            load_ready_q <= load_ready_d;
            mem_write_q <= mem_write_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q <= busy_d;
            done_q <= done_d;
            timeout_q <= timeout_d;
            overflow_q <= overflow_d;
            chk_err_q <= chk_err_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sum_q <= sum_d;
            cycle_count_q <= cycle_count_d;
            load_count_q <= load_count_d;
        end
    end
`ifdef BOOT_CHECKSUM_EN
    assign o_checksum_err = chk_err_q;
`else
    logic unused_checksum;
    assign unused_checksum = ^{i_expected_checksum, chk_err_q, sum_q};
    assign o_checksum_err = 1'b0;
`endif
    assign o_load_ready = load_ready_q;
    assign o_mem_write = mem_write_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_cpu_rst = cpu_rst_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_timeout = timeout_q;
    assign o_overflow = overflow_q;
    assign o_cycle_count = cycle_count_q;
    assign o_load_count = load_count_q;
endmodule
